serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//  Parametrised digit-serial adder/subtractor; successor to the 8-bit bit-serial adder.
//  Processes DIGIT bits per clock over a WIDTH-bit operand pair.
//  Supports add/subtract mode, carry/borrow-in, carry-out and signed overflow.
//  Uses valid/ready handshakes on both sides. Sits between operand staging and result
//  consumers in area-constrained datapaths.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; >= 2
//  DIGIT  1  bits processed per ADD cycle; 1 <= DIGIT <= WIDTH; WIDTH % DIGIT == 0
//  (derived) STEPS = WIDTH/DIGIT, the ADD cycles per operation; CW = clog2(STEPS), min 1
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand bundle valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      0: A+B+cin; 1: A-B-cin (cin acts as borrow)
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  out_valid  out  1      result valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      raw carry out of MSB; for sub, 1 = no borrow
//  ovf        out  1      two's-complement signed overflow
//  busy       out  1      high in ADD or DONE
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): state=IDLE; a_reg, b_reg, sum, count, carry, cout, ovf = 0.
//   Reset has priority over all other events, including mid-ADD and in DONE.
//  FSM states: IDLE, ADD, DONE (encodings 0, 1, 2; 3 is illegal and recovers to IDLE).
//  IDLE: in_ready=1.
//   On in_valid at an edge: a_reg<=a; b_reg<=sub ? ~b : b; carry<=cin^sub; count<=0;
//   the sub flag is latched; -> ADD. Otherwise stay.
//  ADD: each edge computes {c,d} = a_reg[DIGIT-1:0] + b_reg[DIGIT-1:0] + carry.
//   Then: a_reg, b_reg >>= DIGIT; sum <= {d, sum[WIDTH-1:DIGIT]}; carry<=c; count++.
//   On the edge where count==STEPS-1: cout<=c; ovf<=(aM==bM)&&(dM!=aM); -> DONE.
//    aM and bM are the MSBs of the final digits (bM after inversion); dM is the MSB of d.
//  DONE: out_valid=1. sum, cout and ovf are stable. On out_ready at an edge -> IDLE.
//   Otherwise hold indefinitely (backpressure).
//  Latency: out_valid rises STEPS edges after the accepting edge.
//   Minimum initiation interval is STEPS+2 cycles.
//   in_ready=0 in DONE, so there is no same-cycle drain and accept.
//  Inputs a, b, sub and cin are sampled only at acceptance; changes in ADD/DONE are ignored.
//  sum is valid only while out_valid=1; intermediate values during ADD are don't-care.
//  DIGIT==WIDTH: single ADD cycle; count is width 1 and stays 0.
//  Arithmetic is unsigned modulo 2^WIDTH; overflow is reported via ovf and never saturates.
// STRUCTURE
//  serial_addsub_pkg: state enum (IDLE/ADD/DONE); clog2 function; STEPS/CW computation.
//  Sub-module addsub_digit #(DIGIT): combinational DIGIT-bit ripple adder.
//   Ports: x, y, ci -> s, co, plus sign-bit taps for the ovf computation.
//  Top level: FSM, shift registers, counter and handshake logic; one always block per register group.
// TESTING
//  W8/D1 add 0x5A+0x3C, cin=0 -> sum=0x96, cout=0, ovf=1; out_valid 8 cycles after accept.
//  W8/D1 sub 0x10-0x20, cin=0 -> sum=0xF0, cout=0 (borrow), ovf=0; sub 0x7F-0x80 -> 0xFF, ovf=1.
//  W8/D4 add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0; latency 2 cycles.
//   W8/D8 same operands -> latency 1.
//  W8/D1 add 0x7F+0x00, cin=1 -> sum=0x80, ovf=1.
//   Toggle a/b every cycle during ADD -> result unchanged.
//  Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum/cout/ovf stable, in_ready=0.
//   in_valid is ignored; release -> IDLE next edge.
//  Assert rst at count=3 in ADD -> next cycle IDLE, out_valid=0, outputs 0, in_ready=1.
//   A new op then completes correctly.
//  Random regression over W in {8,16,32}, D in {1,2,4,W}: compare to a+/-b model for sum/cout/ovf.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int steps_f(input int w, input int d);
        return w / d;
    endfunction

    // Counter width never drops below one bit, even for a single-step operation.
    function automatic int cw_f(input int w, input int d);
        int c;
        c = clog2_f(w / d);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/serial_addsub_digit.sv
// Combinational DIGIT-bit ripple adder with sign-bit taps for overflow detection.
module addsub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             x_msb,
    output logic             y_msb,
    output logic             s_msb
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
    assign x_msb   = x[DIGIT-1];
    assign y_msb   = y[DIGIT-1];
    assign s_msb   = s[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract: consumes DIGIT bits per cycle, LSB first, with
// valid/ready handshakes on operand and result sides.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int STEPS = steps_f(WIDTH, DIGIT);
    localparam int CW    = cw_f(WIDTH, DIGIT);

    state_e             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic [CW-1:0]      count_q;
    logic               carry_q;
    logic               cout_q;
    logic               ovf_q;

    logic [DIGIT-1:0]       d_s;
    logic                   c_s;
    logic                   am_s;
    logic                   bm_s;
    logic                   dm_s;
    logic                   accept_s;
    logic                   last_s;
    logic                   ovf_d;
    logic [WIDTH+DIGIT-1:0] cat_s;
    logic [WIDTH-1:0]       sum_d;

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .x     (a_q[DIGIT-1:0]),
        .y     (b_q[DIGIT-1:0]),
        .ci    (carry_q),
        .s     (d_s),
        .co    (c_s),
        .x_msb (am_s),
        .y_msb (bm_s),
        .s_msb (dm_s)
    );

    assign accept_s = (state_q == ST_IDLE) && in_valid;
    assign last_s   = (count_q == CW'(STEPS - 1));
    assign ovf_d    = (am_s == bm_s) && (dm_s != am_s);
    // New digit enters at the top so the LSB digit ends up at bit 0 after STEPS shifts.
    assign cat_s    = {d_s, sum_q};
    assign sum_d    = cat_s[WIDTH+DIGIT-1:DIGIT];

    // Control FSM with registered handshake/status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_q    <= ST_ADD;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_ADD: begin
                    if (last_s) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Operand shift registers and running carry; B is pre-inverted for subtraction.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
        end else if (accept_s) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= cin ^ sub;
        end else if (state_q == ST_ADD) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            carry_q <= c_s;
        end
    end

    // Digit step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (accept_s) begin
            count_q <= '0;
        end else if ((state_q == ST_ADD) && !last_s) begin
            count_q <= count_q + CW'(1);
        end
    end

    // Result accumulation and final flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state_q == ST_ADD) begin
            sum_q <= sum_d;
            if (last_s) begin
                cout_q <= c_s;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: three W8 instances (D=1,4,8) and one W16/D2.
module tb_serial_addsub;

    logic       clk;
    logic       rst;
    logic [7:0] a_s, b_s;
    logic       sub_s, cin_s;
    logic       iv_s   [3];
    logic       ordy_s [3];
    logic       irdy_s [3];
    logic       ovld_s [3];
    logic [7:0] sum_s  [3];
    logic       cout_s [3];
    logic       ovf_s  [3];
    logic       busy_s [3];

    logic [15:0] a16, b16, sum16;
    logic        sub16, cin16, iv16, ordy16, irdy16, ovld16, cout16, ovf16, busy16;

    int checks = 0;
    int errors = 0;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv_s[0]), .in_ready(irdy_s[0]),
        .a(a_s), .b(b_s), .sub(sub_s), .cin(cin_s),
        .out_valid(ovld_s[0]), .out_ready(ordy_s[0]),
        .sum(sum_s[0]), .cout(cout_s[0]), .ovf(ovf_s[0]), .busy(busy_s[0]));

    serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(iv_s[1]), .in_ready(irdy_s[1]),
        .a(a_s), .b(b_s), .sub(sub_s), .cin(cin_s),
        .out_valid(ovld_s[1]), .out_ready(ordy_s[1]),
        .sum(sum_s[1]), .cout(cout_s[1]), .ovf(ovf_s[1]), .busy(busy_s[1]));

    serial_addsub #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(iv_s[2]), .in_ready(irdy_s[2]),
        .a(a_s), .b(b_s), .sub(sub_s), .cin(cin_s),
        .out_valid(ovld_s[2]), .out_ready(ordy_s[2]),
        .sum(sum_s[2]), .cout(cout_s[2]), .ovf(ovf_s[2]), .busy(busy_s[2]));

    serial_addsub #(.WIDTH(16), .DIGIT(2)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(irdy16),
        .a(a16), .b(b16), .sub(sub16), .cin(cin16),
        .out_valid(ovld16), .out_ready(ordy16),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .busy(busy16));

    initial clk = 1'b0;
    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation on instance k and count edges until out_valid.
    task automatic do_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                         input logic sb, input logic ci, input bit tog, output int lat);
        a_s = av; b_s = bv; sub_s = sb; cin_s = ci;
        iv_s[k] = 1'b1;
        tick();
        iv_s[k] = 1'b0;
        lat = 0;
        while (ovld_s[k] !== 1'b1 && lat < 40) begin
            if (tog) begin
                a_s = ~a_s; b_s = ~b_s; sub_s = ~sub_s; cin_s = ~cin_s;
            end
            lat++;
            tick();
        end
        chk("op_wait_not_expired", 64'(lat < 40), 64'd1);
    endtask

    task automatic check_res(input int k, input string tag, input logic [7:0] es,
                             input logic ec, input logic eo, input int el, input int lat);
        chk({tag, "_lat"},  lat,       el);
        chk({tag, "_sum"},  sum_s[k],  es);
        chk({tag, "_cout"}, cout_s[k], ec);
        chk({tag, "_ovf"},  ovf_s[k],  eo);
        chk({tag, "_busy"}, busy_s[k], 1'b1);
    endtask

    task automatic drain(input int k, input string tag);
        ordy_s[k] = 1'b1;
        tick();
        ordy_s[k] = 1'b0;
        chk({tag, "_rdy_back"}, irdy_s[k], 1'b1);
        chk({tag, "_vld_drop"}, ovld_s[k], 1'b0);
    endtask

    initial begin
        int lat;
        int ua, ub, ru, sa, sb, rs;
        logic [15:0] es16;
        logic        ec16, eo16;

        rst = 1'b1;
        a_s = 8'h00; b_s = 8'h00; sub_s = 1'b0; cin_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv_s[i] = 1'b0; ordy_s[i] = 1'b0;
        end
        a16 = 16'h0000; b16 = 16'h0000; sub16 = 1'b0; cin16 = 1'b0;
        iv16 = 1'b0; ordy16 = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready",  irdy_s[i], 1'b1);
            chk("rst_out_valid", ovld_s[i], 1'b0);
            chk("rst_sum",       sum_s[i],  8'h00);
            chk("rst_busy",      busy_s[i], 1'b0);
        end
        chk("rst16_in_ready", irdy16, 1'b1);

        do_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, lat);
        check_res(0, "d1_add", 8'h96, 1'b0, 1'b1, 8, lat);
        chk("d1_add_in_ready_done", irdy_s[0], 1'b0);
        drain(0, "d1_add");

        do_op(0, 8'h10, 8'h20, 1'b1, 1'b0, 1'b0, lat);
        check_res(0, "d1_sub", 8'hF0, 1'b0, 1'b0, 8, lat);
        drain(0, "d1_sub");

        do_op(0, 8'h7F, 8'h80, 1'b1, 1'b0, 1'b0, lat);
        check_res(0, "d1_sub_ovf", 8'hFF, 1'b0, 1'b1, 8, lat);
        drain(0, "d1_sub_ovf");

        do_op(1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, lat);
        check_res(1, "d4_add", 8'h00, 1'b1, 1'b0, 2, lat);
        drain(1, "d4_add");

        do_op(2, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, lat);
        check_res(2, "d8_add", 8'h00, 1'b1, 1'b0, 1, lat);
        drain(2, "d8_add");

        do_op(1, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, lat);
        check_res(1, "d4_neg_ovf", 8'h00, 1'b1, 1'b1, 2, lat);
        drain(1, "d4_neg_ovf");

        // Operand inputs flip every ADD cycle; only the accepted values matter.
        do_op(0, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b1, lat);
        check_res(0, "d1_cin_tog", 8'h80, 1'b0, 1'b1, 8, lat);
        drain(0, "d1_cin_tog");

        do_op(0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, lat);
        check_res(0, "d1_borrow_in", 8'hFF, 1'b0, 1'b0, 8, lat);
        drain(0, "d1_borrow_in");

        do_op(0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, lat);
        check_res(0, "d1_bp", 8'h46, 1'b0, 1'b0, 8, lat);
        a_s = 8'hFF; b_s = 8'hFF;
        iv_s[0] = 1'b1;
        repeat (5) begin
            tick();
            chk("bp_sum",       sum_s[0],  8'h46);
            chk("bp_cout",      cout_s[0], 1'b0);
            chk("bp_in_ready",  irdy_s[0], 1'b0);
            chk("bp_out_valid", ovld_s[0], 1'b1);
        end
        iv_s[0] = 1'b0;
        drain(0, "d1_bp");

        a_s = 8'hC3; b_s = 8'h3C; sub_s = 1'b0; cin_s = 1'b0;
        iv_s[0] = 1'b1;
        tick();
        iv_s[0] = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready",  irdy_s[0], 1'b1);
        chk("mid_rst_out_valid", ovld_s[0], 1'b0);
        chk("mid_rst_busy",      busy_s[0], 1'b0);
        chk("mid_rst_sum",       sum_s[0],  8'h00);
        chk("mid_rst_cout",      cout_s[0], 1'b0);
        chk("mid_rst_ovf",       ovf_s[0],  1'b0);
        tick();
        chk("mid_rst_stays_idle", ovld_s[0], 1'b0);

        do_op(0, 8'hA5, 8'h5A, 1'b0, 1'b0, 1'b0, lat);
        check_res(0, "post_rst", 8'hFF, 1'b0, 1'b0, 8, lat);
        drain(0, "post_rst");

        // Randomised W16/D2 against a signed/unsigned integer model.
        for (int n = 0; n < 8; n++) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            sub16 = 1'($urandom_range(0, 1)); cin16 = 1'($urandom_range(0, 1));
            ua = int'(a16); ub = int'(b16);
            sa = int'($signed(a16)); sb = int'($signed(b16));
            if (sub16) begin
                ru = ua - ub - int'(cin16);
                rs = sa - sb - int'(cin16);
                ec16 = (ru >= 0);
            end else begin
                ru = ua + ub + int'(cin16);
                rs = sa + sb + int'(cin16);
                ec16 = (ru > 65535);
            end
            es16 = ru[15:0];
            eo16 = (rs > 32767) || (rs < -32768);
            iv16 = 1'b1;
            tick();
            iv16 = 1'b0;
            lat = 0;
            while (ovld16 !== 1'b1 && lat < 40) begin
                lat++;
                tick();
            end
            chk("w16_wait_not_expired", 64'(lat < 40), 64'd1);
            chk("w16_lat",  lat,    8);
            chk("w16_sum",  sum16,  es16);
            chk("w16_cout", cout16, ec16);
            chk("w16_ovf",  ovf16,  eo16);
            ordy16 = 1'b1;
            tick();
            ordy16 = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
